// File: rtl/spell_reg_loader.sv
// spell_reg_loader: moves one 8-bit CPU register through a serial load or
// dump chain. A transfer is SETUP, then 8 bit periods of CLK_DIV cycles in
// SHIFT, then HOLD and a one-cycle DONE. All outputs are registered.
module spell_reg_loader #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_write,
  input  logic [1:0] i_sel,
  input  logic [7:0] i_wdata,
  input  logic       i_abort,
  input  logic       i_shift_out,
  output logic       o_shift_in,
  output logic       o_load,
  output logic       o_dump,
  output logic [1:0] o_reg_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // Last value of the divider count; the bit period ends when it is reached.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic       wr;       // captured direction: 1 = load, 0 = dump
  logic [7:0] tx_sh;    // write data, MSB presented first
  logic [7:0] rx_sh;    // read data, first sample ends up in bit 7
  logic [7:0] div_cnt;  // cycle within the current bit period
  logic [2:0] bit_cnt;  // bit period index 0..7

  // Transfer sequencer; every output is driven from this one register block.
  // NOTE: all state and outputs are assigned with <= so every update in this
  // block sees the values from before the clock edge, as flops do.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: control state and outputs take the asynchronous reset; the
    // transfer shift registers are reset too so no X can reach o_rdata.
    if (rst) begin
      state      <= IDLE;
      wr         <= 1'b0;
      tx_sh      <= 8'h00;
      rx_sh      <= 8'h00;
      div_cnt    <= 8'h00;
      bit_cnt    <= 3'd0;
      o_shift_in <= 1'b0;
      o_load     <= 1'b0;
      o_dump     <= 1'b0;
      o_reg_sel  <= 2'd0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rdata    <= 8'h00;
    end else begin
      // o_done is a single-cycle pulse unless HOLD sets it below
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          // i_abort has no meaning here; only i_start is looked at
          if (i_start) begin
            wr        <= i_write;
            o_reg_sel <= i_sel;
            tx_sh     <= i_wdata;
            rx_sh     <= 8'h00;
            div_cnt   <= 8'h00;
            bit_cnt   <= 3'd0;
            o_busy    <= 1'b1;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (i_abort) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_load     <= 1'b0;
            o_dump     <= 1'b0;
            o_shift_in <= 1'b0;
          end else begin
            state      <= SHIFT;
            o_load     <= wr;
            o_dump     <= ~wr;
            o_shift_in <= wr & tx_sh[7];
          end
        end

        SHIFT: begin
          if (i_abort) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_load     <= 1'b0;
            o_dump     <= 1'b0;
            o_shift_in <= 1'b0;
            div_cnt    <= 8'h00;
            bit_cnt    <= 3'd0;
          end else if (div_cnt == DIV_LAST) begin
            // last cycle of the bit period: sample the dump chain
            div_cnt <= 8'h00;
            rx_sh   <= {rx_sh[6:0], i_shift_out};
            if (bit_cnt == 3'd7) begin
              bit_cnt    <= 3'd0;
              state      <= HOLD;
              o_load     <= 1'b0;
              o_dump     <= 1'b0;
              o_shift_in <= 1'b0;
            end else begin
              bit_cnt    <= bit_cnt + 3'd1;
              tx_sh      <= {tx_sh[6:0], 1'b0};
              o_shift_in <= wr & tx_sh[6];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (i_abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            if (!wr) begin
              o_rdata <= rx_sh;
            end
          end
        end

        DONE: begin
          // i_start here is deliberately ignored
          state <= IDLE;
        end

        default: begin
          state      <= IDLE;
          o_busy     <= 1'b0;
          o_load     <= 1'b0;
          o_dump     <= 1'b0;
          o_shift_in <= 1'b0;
        end
      endcase
    end
  end

endmodule
